// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    FLASH   = 2'd3
  } state_t;

  // Index width for n approaches, never narrower than one bit.
  function automatic int dirWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among pending approaches: the search starts just after
// the last-served approach, wraps around, and checks that approach itself last.
module rr_arbiter
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = dirWidth(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] pending,
  input  logic [DIR_W-1:0]   active_dir,
  output logic               grant_valid,
  output logic [DIR_W-1:0]   grant_idx
);

  // First pending bit found walking forward from active_dir+1 wins.
  always_comb begin
    int idx;
    logic [DIR_W-1:0] sel;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    sel         = '0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      idx = int'(active_dir) + k;
      if (idx >= NUM_DIR) idx = idx - NUM_DIR;
      sel = DIR_W'(idx);
      if (!grant_valid && pending[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Multi-approach traffic-light controller: timed GREEN -> YELLOW -> ALL_RED
// phases counted in ticks, round-robin service of latched demand with
// min/max green and gap-out, plus a maintenance flash mode.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR     = 4,
  parameter int CNT_W       = 8,
  parameter int GREEN_MIN   = 10,
  parameter int GREEN_MAX   = 30,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  localparam int DIR_W      = dirWidth(NUM_DIR)
) (
  input  logic               clock,
  input  logic               resetL,
  input  logic               tick,
  input  logic [NUM_DIR-1:0] req,
  input  logic               flash,
  output logic [NUM_DIR-1:0] redout,
  output logic [NUM_DIR-1:0] yellowout,
  output logic [NUM_DIR-1:0] greenout,
  output logic [DIR_W-1:0]   active_dir,
  output logic [NUM_DIR-1:0] pending
);

  localparam logic [CNT_W:0] GMIN  = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0] GMAX  = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0] YTIME = (CNT_W+1)'(YELLOW_TIME);
  localparam logic [CNT_W:0] RTIME = (CNT_W+1)'(ALLRED_TIME);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               blink;

  logic               grant_valid;
  logic [DIR_W-1:0]   grant_idx;
  logic [NUM_DIR-1:0] dir_mask;
  logic [NUM_DIR-1:0] grant_mask;
  logic [NUM_DIR-1:0] req_latch;
  logic [NUM_DIR-1:0] other;
  logic [CNT_W:0]     elapsed;
  logic [CNT_W-1:0]   count_inc;

  rr_arbiter #(.NUM_DIR(NUM_DIR), .DIR_W(DIR_W)) u_arb (
    .pending    (pending),
    .active_dir (active_dir),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  // The served approach's own request only stretches its green and is not latched.
  assign dir_mask   = NUM_DIR'(1) << active_dir;
  assign grant_mask = NUM_DIR'(1) << grant_idx;
  assign req_latch  = req & ~((state == GREEN) ? dir_mask : '0);
  assign other      = pending & ~dir_mask;
  assign elapsed    = {1'b0, count} + (CNT_W+1)'(1);
  assign count_inc  = (count == '1) ? count : count + CNT_W'(1);

  // Phase sequencing, demand latching and flash blink; flash overrides everything.
  always_ff @(posedge clock or negedge resetL) begin
    if (!resetL) begin
      state      <= ALL_RED;
      count      <= '0;
      active_dir <= '0;
      pending    <= '0;
      blink      <= 1'b0;
    end else begin
      pending <= pending | req_latch;
      if (flash) begin
        if (state != FLASH) begin
          state <= FLASH;
          count <= '0;
        end else if (tick) begin
          blink <= ~blink;
          count <= count_inc;
        end
      end else begin
        case (state)
          ALL_RED: begin
            if (tick) begin
              if (elapsed >= RTIME && grant_valid) begin
                state      <= GREEN;
                count      <= '0;
                active_dir <= grant_idx;
                pending    <= (pending | req_latch) & ~grant_mask;
              end else begin
                count <= count_inc;
              end
            end
          end
          GREEN: begin
            if (tick) begin
              if (other != '0 &&
                  ((elapsed >= GMIN && !req[active_dir]) || elapsed >= GMAX)) begin
                state <= YELLOW;
                count <= '0;
              end else begin
                count <= count_inc;
              end
            end
          end
          YELLOW: begin
            if (tick) begin
              if (elapsed >= YTIME) begin
                state <= ALL_RED;
                count <= '0;
              end else begin
                count <= count_inc;
              end
            end
          end
          FLASH: begin
            state <= ALL_RED;
            count <= '0;
          end
          default: begin
            state <= ALL_RED;
            count <= '0;
          end
        endcase
      end
    end
  end

  // Lamp decode straight from registered state, served approach and blink phase.
  always_comb begin
    redout    = '1;
    yellowout = '0;
    greenout  = '0;
    case (state)
      GREEN: begin
        greenout = dir_mask;
        redout   = ~dir_mask;
      end
      YELLOW: begin
        yellowout = dir_mask;
        redout    = ~dir_mask;
      end
      FLASH: begin
        redout    = '0;
        yellowout = {NUM_DIR{blink}};
      end
      default: begin
        redout = '1;
      end
    endcase
  end

endmodule
